if_fetch_unit: RTL and testbench

//  Instruction-fetch front end; producer side of the IF/ID pipeline register. Owns fetch PC,

---
 rtl/if_fetch_unit.sv | 109 ++++++++++
 tb/tb_if_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Brief    : Instruction-fetch front end feeding the IF/ID pipeline register
//             (single-outstanding imem read, small {pc,instr} buffer).
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_pending_target;
  logic               r_drop;
  logic [c_PTR_W:0]   r_count;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [31:0]        r_pc_buf    [DEPTH];
  logic [31:0]        r_instr_buf [DEPTH];

  logic        w_not_full;
  logic        w_complete;
  logic        w_push;
  logic        w_pop;
  logic        w_valid;
  logic [31:0] w_target;

  // While a redirected read is being drained the request must stay up
  // regardless of buffer occupancy.
  assign w_not_full = (r_count < (c_PTR_W+1)'(DEPTH));
  assign IMEM_READ  = ~RESET & (w_not_full | r_drop);
  assign IMEM_ADDR  = r_fetch_pc;
  assign w_complete = IMEM_READ & ~IMEM_BUSYWAIT;
  assign w_target   = BRANCH_TARGET & ~32'h0000_0003;

  assign w_valid = ~RESET & (r_count != '0);
  assign w_push  = w_complete & ~BRANCH_TAKEN & ~r_drop;
  assign w_pop   = w_valid & ~STALL & ~BRANCH_TAKEN;

  assign IF_VALID = w_valid;
  assign IF_PC    = w_valid ? r_pc_buf[r_rd_ptr]    : 32'h0000_0000;
  assign IF_INSTR = w_valid ? r_instr_buf[r_rd_ptr] : NOP_INSTR;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_pc_buf[r_wr_ptr]    <= r_fetch_pc;
      r_instr_buf[r_wr_ptr] <= IMEM_READDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fetch_pc       <= RESET_PC;
      r_pending_target <= 32'h0000_0000;
      r_drop           <= 1'b0;
      r_count          <= '0;
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
    end else if (BRANCH_TAKEN) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      // A read still waiting on memory cannot be cancelled: remember the
      // target and swallow that response when it finally arrives.
      if (!IMEM_READ || w_complete) begin
        r_fetch_pc <= w_target;
        r_drop     <= 1'b0;
      end else begin
        r_drop           <= 1'b1;
        r_pending_target <= w_target;
      end
    end else begin
      if (w_complete) begin
        if (r_drop) begin
          r_fetch_pc <= r_pending_target;
          r_drop     <= 1'b0;
        end else begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_unit
//  Brief    : Self-checking bench for if_fetch_unit with a {pc,instr} scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] c_NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_READDATA;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic        IF_VALID;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];
  logic [31:0] m_pc   = c_RESET_PC;
  logic [31:0] m_pend = 32'h0;
  logic        m_drop = 1'b0;

  if_fetch_unit #(.RESET_PC(c_RESET_PC), .DEPTH(2), .NOP_INSTR(c_NOP)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_READ(IMEM_READ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .IF_PC(IF_PC), .IF_INSTR(IF_INSTR), .IF_VALID(IF_VALID)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign IMEM_READDATA = mem_fn(IMEM_ADDR);

  task automatic drive(input logic rst, input logic stall, input logic busy,
                       input logic br, input logic [31:0] tgt);
    @(negedge CLK);
    RESET = rst; STALL = stall; IMEM_BUSYWAIT = busy;
    BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc = c_RESET_PC; m_pend = 32'h0; m_drop = 1'b0;
  endtask

  // Advances the reference model across the coming rising edge.
  task automatic model_step(input logic stall, input logic busy,
                            input logic br, input logic [31:0] tgt);
    logic rd, comp;
    ent_t e;
    rd   = m_drop | (sb.size() < 2);
    comp = rd & ~busy;
    if (br) begin
      sb.delete();
      if (!rd || comp) begin m_pc = tgt & ~32'h3; m_drop = 1'b0; end
      else begin m_drop = 1'b1; m_pend = tgt & ~32'h3; end
    end else begin
      if (sb.size() > 0 && !stall) e = sb.pop_front();
      if (comp) begin
        if (m_drop) begin m_pc = m_pend; m_drop = 1'b0; end
        else begin
          e.pc = m_pc; e.instr = mem_fn(m_pc); sb.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (IMEM_READ !== 1'b0) begin n_err++; $display("FAIL reset_read k=%0d got %b exp 0", k, IMEM_READ); end
      n_cmp++; if (IF_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid k=%0d got %b exp 0", k, IF_VALID); end
      n_cmp++; if (IF_PC !== 32'h0) begin n_err++; $display("FAIL reset_pc k=%0d got %h exp 0", k, IF_PC); end
      n_cmp++; if (IF_INSTR !== c_NOP) begin n_err++; $display("FAIL reset_instr k=%0d got %h exp %h", k, IF_INSTR, c_NOP); end
    end
    model_reset();
  endtask

  task automatic test_zero_wait();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (IMEM_READ !== 1'b1) begin n_err++; $display("FAIL zw_read k=%0d got %b exp 1", k, IMEM_READ); end
      n_cmp++; if (IMEM_ADDR !== 32'(k * 4)) begin n_err++; $display("FAIL zw_addr k=%0d got %h exp %h", k, IMEM_ADDR, 32'(k * 4)); end
      n_cmp++; if (IF_VALID !== (k > 0)) begin n_err++; $display("FAIL zw_valid k=%0d got %b exp %b", k, IF_VALID, k > 0); end
      if (sb.size() > 0) begin
        n_cmp++; if (IF_PC !== sb[0].pc) begin n_err++; $display("FAIL zw_pc k=%0d got %h exp %h", k, IF_PC, sb[0].pc); end
        n_cmp++; if (IF_INSTR !== sb[0].instr) begin n_err++; $display("FAIL zw_instr k=%0d got %h exp %h", k, IF_INSTR, sb[0].instr); end
      end
      model_step(1'b0, 1'b0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_busywait();
    logic busy;
    for (int k = 0; k < 16; k++) begin
      busy = (k % 4 != 3);
      drive(1'b0, 1'b0, busy, 1'b0, 32'h0);
      n_cmp++; if (IMEM_READ !== 1'b1) begin n_err++; $display("FAIL bw_read k=%0d got %b exp 1", k, IMEM_READ); end
      n_cmp++; if (IMEM_ADDR !== m_pc) begin n_err++; $display("FAIL bw_addr k=%0d got %h exp %h", k, IMEM_ADDR, m_pc); end
      n_cmp++; if (IF_VALID !== (k % 4 == 0)) begin n_err++; $display("FAIL bw_valid k=%0d got %b exp %b", k, IF_VALID, k % 4 == 0); end
      if (sb.size() > 0) begin
        n_cmp++; if (IF_PC !== sb[0].pc) begin n_err++; $display("FAIL bw_pc k=%0d got %h exp %h", k, IF_PC, sb[0].pc); end
        n_cmp++; if (IF_INSTR !== sb[0].instr) begin n_err++; $display("FAIL bw_instr k=%0d got %h exp %h", k, IF_INSTR, sb[0].instr); end
      end else begin
        n_cmp++; if (IF_INSTR !== c_NOP) begin n_err++; $display("FAIL bw_nop k=%0d got %h exp %h", k, IF_INSTR, c_NOP); end
      end
      model_step(1'b0, busy, 1'b0, 32'h0);
    end
  endtask

  task automatic test_stall();
    logic        stall;
    logic [31:0] held;
    held = (sb.size() > 0) ? sb[0].pc : 32'hDEAD_BEEF;
    for (int k = 0; k < 10; k++) begin
      stall = (k < 5);
      drive(1'b0, stall, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (IMEM_READ !== !(k >= 1 && k <= 5)) begin n_err++; $display("FAIL st_read k=%0d got %b exp %b", k, IMEM_READ, !(k >= 1 && k <= 5)); end
      n_cmp++; if (IMEM_ADDR !== m_pc) begin n_err++; $display("FAIL st_addr k=%0d got %h exp %h", k, IMEM_ADDR, m_pc); end
      n_cmp++; if (IF_VALID !== 1'b1) begin n_err++; $display("FAIL st_valid k=%0d got %b exp 1", k, IF_VALID); end
      if (k <= 5) begin
        n_cmp++; if (IF_PC !== held) begin n_err++; $display("FAIL st_hold k=%0d got %h exp %h", k, IF_PC, held); end
      end
      if (sb.size() > 0) begin
        n_cmp++; if (IF_PC !== sb[0].pc) begin n_err++; $display("FAIL st_pc k=%0d got %h exp %h", k, IF_PC, sb[0].pc); end
        n_cmp++; if (IF_INSTR !== sb[0].instr) begin n_err++; $display("FAIL st_instr k=%0d got %h exp %h", k, IF_INSTR, sb[0].instr); end
      end
      model_step(stall, 1'b0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_branch_full();
    logic stall, br;
    for (int k = 0; k < 8; k++) begin
      stall = (k < 3);
      br    = (k == 3);
      drive(1'b0, stall, 1'b0, br, 32'h0000_0100);
      n_cmp++; if (IMEM_READ !== (m_drop | (sb.size() < 2))) begin n_err++; $display("FAIL bf_read k=%0d got %b exp %b", k, IMEM_READ, sb.size() < 2); end
      if (k == 3) begin
        n_cmp++; if (IMEM_READ !== 1'b0) begin n_err++; $display("FAIL bf_full k=%0d got %b exp 0", k, IMEM_READ); end
      end
      if (k == 4) begin
        n_cmp++; if (IMEM_ADDR !== 32'h100) begin n_err++; $display("FAIL bf_addr k=%0d got %h exp 00000100", k, IMEM_ADDR); end
        n_cmp++; if (IF_VALID !== 1'b0) begin n_err++; $display("FAIL bf_flush k=%0d got %b exp 0", k, IF_VALID); end
      end
      if (k == 5) begin
        n_cmp++; if (IF_PC !== 32'h100) begin n_err++; $display("FAIL bf_tgt k=%0d got %h exp 00000100", k, IF_PC); end
      end
      n_cmp++; if (IF_VALID !== (sb.size() > 0)) begin n_err++; $display("FAIL bf_valid k=%0d got %b exp %b", k, IF_VALID, sb.size() > 0); end
      if (sb.size() > 0) begin
        n_cmp++; if (IF_PC !== sb[0].pc) begin n_err++; $display("FAIL bf_pc k=%0d got %h exp %h", k, IF_PC, sb[0].pc); end
      end
      model_step(stall, 1'b0, br, 32'h0000_0100);
    end
  endtask

  task automatic test_redirect_busy();
    logic        busy_t [9];
    logic        br_t   [9];
    logic [31:0] tgt_t  [9];
    busy_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    br_t   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tgt_t  = '{32'h40, 32'h0, 32'h303, 32'h203, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 1'b0, busy_t[k], br_t[k], tgt_t[k]);
      if (k >= 1 && k <= 5) begin
        n_cmp++; if (IMEM_ADDR !== 32'h40) begin n_err++; $display("FAIL rb_hold k=%0d got %h exp 00000040", k, IMEM_ADDR); end
        n_cmp++; if (IMEM_READ !== 1'b1) begin n_err++; $display("FAIL rb_read k=%0d got %b exp 1", k, IMEM_READ); end
      end
      if (k >= 1 && k <= 6) begin
        n_cmp++; if (IF_VALID !== 1'b0) begin n_err++; $display("FAIL rb_drop k=%0d got %b exp 0", k, IF_VALID); end
      end
      if (k == 6) begin
        n_cmp++; if (IMEM_ADDR !== 32'h200) begin n_err++; $display("FAIL rb_addr k=%0d got %h exp 00000200", k, IMEM_ADDR); end
      end
      if (k == 7) begin
        n_cmp++; if (IF_PC !== 32'h200) begin n_err++; $display("FAIL rb_pc k=%0d got %h exp 00000200", k, IF_PC); end
        n_cmp++; if (IF_INSTR !== mem_fn(32'h200)) begin n_err++; $display("FAIL rb_instr k=%0d got %h exp %h", k, IF_INSTR, mem_fn(32'h200)); end
      end
      n_cmp++; if (IMEM_ADDR !== m_pc) begin n_err++; $display("FAIL rb_model k=%0d got %h exp %h", k, IMEM_ADDR, m_pc); end
      model_step(1'b0, busy_t[k], br_t[k], tgt_t[k]);
    end
  endtask

  task automatic test_reset_wrap();
    logic        rst_t   [10];
    logic        stall_t [10];
    logic        busy_t  [10];
    logic        br_t    [10];
    logic [31:0] tgt_t   [10];
    rst_t   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    stall_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    busy_t  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    br_t    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tgt_t   = '{32'h0, 32'h500, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    for (int k = 0; k < 10; k++) begin
      drive(rst_t[k], stall_t[k], busy_t[k], br_t[k], tgt_t[k]);
      if (rst_t[k]) begin
        n_cmp++; if (IMEM_READ !== 1'b0) begin n_err++; $display("FAIL rw_rread k=%0d got %b exp 0", k, IMEM_READ); end
        n_cmp++; if (IF_VALID !== 1'b0) begin n_err++; $display("FAIL rw_rvalid k=%0d got %b exp 0", k, IF_VALID); end
        n_cmp++; if (IF_INSTR !== c_NOP) begin n_err++; $display("FAIL rw_rnop k=%0d got %h exp %h", k, IF_INSTR, c_NOP); end
        model_reset();
      end else begin
        n_cmp++; if (IMEM_READ !== (m_drop | (sb.size() < 2))) begin n_err++; $display("FAIL rw_read k=%0d got %b exp %b", k, IMEM_READ, m_drop | (sb.size() < 2)); end
        n_cmp++; if (IMEM_ADDR !== m_pc) begin n_err++; $display("FAIL rw_addr k=%0d got %h exp %h", k, IMEM_ADDR, m_pc); end
        n_cmp++; if (IF_VALID !== (sb.size() > 0)) begin n_err++; $display("FAIL rw_valid k=%0d got %b exp %b", k, IF_VALID, sb.size() > 0); end
        if (sb.size() > 0) begin
          n_cmp++; if (IF_PC !== sb[0].pc) begin n_err++; $display("FAIL rw_pc k=%0d got %h exp %h", k, IF_PC, sb[0].pc); end
          n_cmp++; if (IF_INSTR !== sb[0].instr) begin n_err++; $display("FAIL rw_instr k=%0d got %h exp %h", k, IF_INSTR, sb[0].instr); end
        end
        if (k == 4) begin
          n_cmp++; if (IMEM_ADDR !== c_RESET_PC) begin n_err++; $display("FAIL rw_rpc k=%0d got %h exp %h", k, IMEM_ADDR, c_RESET_PC); end
        end
        if (k == 8) begin
          n_cmp++; if (IMEM_ADDR !== 32'h0) begin n_err++; $display("FAIL rw_wrap k=%0d got %h exp 00000000", k, IMEM_ADDR); end
          n_cmp++; if (IF_PC !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL rw_top k=%0d got %h exp fffffffc", k, IF_PC); end
        end
        if (k == 9) begin
          n_cmp++; if (IF_PC !== 32'h0) begin n_err++; $display("FAIL rw_pc0 k=%0d got %h exp 00000000", k, IF_PC); end
        end
        model_step(stall_t[k], busy_t[k], br_t[k], tgt_t[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_busywait();
    test_stall();
    test_branch_full();
    test_redirect_busy();
    test_reset_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
